// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - game-flow controller for the 4x4 tic-tac-toe board datapath
module turn_sequencer #(
    parameter int         SCORE_W     = 4,
    parameter int         TIMEOUT_CYC = 1000,
    parameter logic [1:0] FIRST_MOVER = 2'b01
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pl_req,
    input  logic [3:0]         pl_pos,
    input  logic               pc_req,
    input  logic [3:0]         pc_pos,
    input  logic               new_game,
    input  logic               illegal_move,
    input  logic               win,
    input  logic [1:0]         winner,
    input  logic               no_space,
    output logic [3:0]         chk_pos,
    output logic               pl_ack,
    output logic               pc_ack,
    output logic               pl_nack,
    output logic               pc_nack,
    output logic               wr_en,
    output logic [3:0]         wr_pos,
    output logic [1:0]         wr_who,
    output logic               board_clr,
    output logic [1:0]         turn,
    output logic [4:0]         move_count,
    output logic               game_over,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] pl_score,
    output logic [SCORE_W-1:0] pc_score,
    output logic               timeout_pulse
);

    localparam int          TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT,
        S_COMMIT,
        S_EVAL,
        S_OVER
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_side;
    logic [1:0]         r_next_first;
    logic [TW-1:0]      r_timer;
    logic [4:0]         r_move_count;
    logic [1:0]         r_result;
    logic [SCORE_W-1:0] r_pl_score;
    logic [SCORE_W-1:0] r_pc_score;
    logic [3:0]         r_wr_pos;
    logic [1:0]         r_wr_who;

    logic               w_is_pl;
    logic               w_req;
    logic [3:0]         w_pos;
    logic               w_accept;
    logic               w_timeout;

    assign w_is_pl    = (r_side == 2'b01);
    assign w_req      = w_is_pl ? pl_req : pc_req;
    assign w_pos      = w_is_pl ? pl_pos : pc_pos;
    assign move_count = r_move_count;
    assign result     = r_result;
    assign pl_score   = r_pl_score;
    assign pc_score   = r_pc_score;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_timeout     = 1'b0;
        chk_pos       = 4'd0;
        pl_ack        = 1'b0;
        pc_ack        = 1'b0;
        pl_nack       = 1'b0;
        pc_nack       = 1'b0;
        wr_en         = 1'b0;
        wr_pos        = 4'd0;
        wr_who        = 2'b00;
        board_clr     = 1'b0;
        turn          = 2'b00;
        game_over     = 1'b0;
        timeout_pulse = 1'b0;
        case (r_state)
            S_CLEAR: begin
                board_clr    = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                turn    = r_side;
                chk_pos = w_pos;
                if (w_req && !illegal_move) begin
                    w_accept     = 1'b1;
                    pl_ack       = w_is_pl;
                    pc_ack       = !w_is_pl;
                    w_next_state = S_COMMIT;
                end else if (w_req) begin
                    pl_nack = w_is_pl;
                    pc_nack = !w_is_pl;
                end
                // Acceptance in the expiring cycle wins; the forfeit is suppressed.
                if (!w_accept && (r_timer == TMAX)) begin
                    w_timeout     = 1'b1;
                    timeout_pulse = 1'b1;
                end
            end
            S_COMMIT: begin
                wr_en        = 1'b1;
                wr_pos       = r_wr_pos;
                wr_who       = r_wr_who;
                w_next_state = S_EVAL;
            end
            S_EVAL: begin
                w_next_state = (win || no_space) ? S_OVER : S_WAIT;
            end
            S_OVER: begin
                game_over = 1'b1;
                if (new_game) begin
                    w_next_state = S_CLEAR;
                end
            end
            default: begin
                w_next_state = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_side       <= FIRST_MOVER;
            r_next_first <= FIRST_MOVER;
            r_timer      <= '0;
            r_move_count <= 5'd0;
            r_result     <= 2'b00;
            r_pl_score   <= '0;
            r_pc_score   <= '0;
            r_wr_pos     <= 4'd0;
            r_wr_who     <= 2'b00;
        end else begin
            r_timer <= '0;
            case (r_state)
                S_CLEAR: begin
                    r_side       <= r_next_first;
                    r_next_first <= ~r_next_first;
                    r_move_count <= 5'd0;
                    r_result     <= 2'b00;
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_wr_pos <= w_pos;
                        r_wr_who <= r_side;
                    end else if (w_timeout) begin
                        r_side <= ~r_side;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (r_move_count != 5'd16) begin
                        r_move_count <= r_move_count + 5'd1;
                    end
                end
                S_EVAL: begin
                    if (win) begin
                        r_result <= winner;
                        if ((winner == 2'b01) && (r_pl_score != {SCORE_W{1'b1}})) begin
                            r_pl_score <= r_pl_score + 1'b1;
                        end
                        if ((winner == 2'b10) && (r_pc_score != {SCORE_W{1'b1}})) begin
                            r_pc_score <= r_pc_score + 1'b1;
                        end
                    end else if (no_space) begin
                        r_result <= 2'b11;
                    end else begin
                        r_side <= ~r_side;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - randomized game-level bench for turn_sequencer
module tb_turn_sequencer;

    localparam int TO   = 8;
    localparam int SW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          clock;
    logic          reset;
    logic          pl_req;
    logic [3:0]    pl_pos;
    logic          pc_req;
    logic [3:0]    pc_pos;
    logic          new_game;
    logic          illegal_move;
    logic          win;
    logic [1:0]    winner;
    logic          no_space;
    logic [3:0]    chk_pos;
    logic          pl_ack;
    logic          pc_ack;
    logic          pl_nack;
    logic          pc_nack;
    logic          wr_en;
    logic [3:0]    wr_pos;
    logic [1:0]    wr_who;
    logic          board_clr;
    logic [1:0]    turn;
    logic [4:0]    move_count;
    logic          game_over;
    logic [1:0]    result;
    logic [SW-1:0] pl_score;
    logic [SW-1:0] pc_score;
    logic          timeout_pulse;

    turn_sequencer #(
        .SCORE_W    (SW),
        .TIMEOUT_CYC(TO),
        .FIRST_MOVER(2'b01)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pl_req       (pl_req),
        .pl_pos       (pl_pos),
        .pc_req       (pc_req),
        .pc_pos       (pc_pos),
        .new_game     (new_game),
        .illegal_move (illegal_move),
        .win          (win),
        .winner       (winner),
        .no_space     (no_space),
        .chk_pos      (chk_pos),
        .pl_ack       (pl_ack),
        .pc_ack       (pc_ack),
        .pl_nack      (pl_nack),
        .pc_nack      (pc_nack),
        .wr_en        (wr_en),
        .wr_pos       (wr_pos),
        .wr_who       (wr_who),
        .board_clr    (board_clr),
        .turn         (turn),
        .move_count   (move_count),
        .game_over    (game_over),
        .result       (result),
        .pl_score     (pl_score),
        .pc_score     (pc_score),
        .timeout_pulse(timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks;
    int         n_errors;
    logic [1:0] m_side;
    logic [1:0] m_first_next;
    logic [1:0] m_result;
    logic [3:0] m_pend_pos;
    logic [1:0] m_pend_side;
    int         m_moves;
    int         m_wait;
    int         m_pl;
    int         m_pc;
    bit         m_board [16];
    bit         m_over;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] other(input logic [1:0] s);
        return (s == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick_cell(input bit want_used);
        int s;
        s = int'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) begin
            if (m_board[(s + i) % 16] == want_used) return (s + i) % 16;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pl_req       = 1'b0;
        pc_req       = 1'b0;
        pl_pos       = 4'($urandom_range(0, 15));
        pc_pos       = 4'($urandom_range(0, 15));
        new_game     = 1'b0;
        illegal_move = 1'b0;
        win          = 1'b0;
        winner       = 2'b00;
        no_space     = 1'b0;
    endtask

    task automatic model_clear();
        m_side       = m_first_next;
        m_first_next = other(m_first_next);
        m_moves      = 0;
        m_result     = 2'b00;
        m_wait       = 0;
        m_over       = 1'b0;
        for (int i = 0; i < 16; i++) m_board[i] = 1'b0;
    endtask

    // kind: 0 idle, 1 other side requests, 2 occupied cell, 3 free cell
    task automatic wait_cycle(input int kind_in);
        int         kind;
        int         c;
        logic [3:0] pos;
        bit         e_ack;
        bit         e_nack;
        bit         e_to;
        kind = kind_in;
        c    = 0;
        idle_inputs();
        new_game = 1'($urandom_range(0, 1));
        if (kind == 2) begin
            c = pick_cell(1'b1);
            if (c < 0) kind = 0;
        end
        if (kind == 3) pos = 4'(pick_cell(1'b0));
        else if (kind == 2) pos = 4'(c);
        else pos = 4'($urandom_range(0, 15));
        if (m_side == 2'b01) begin
            pl_pos = pos;
            pl_req = (kind >= 2);
            pc_req = (kind == 1);
        end else begin
            pc_pos = pos;
            pc_req = (kind >= 2);
            pl_req = (kind == 1);
        end
        illegal_move = m_board[pos];
        #1;
        e_ack  = (kind == 3);
        e_nack = (kind == 2);
        e_to   = !e_ack && (m_wait == TO - 1);
        check("wait_turn",    32'(turn),          32'(m_side));
        check("wait_chk_pos", 32'(chk_pos),       32'(pos));
        check("wait_pl_ack",  32'(pl_ack),        32'(e_ack && m_side == 2'b01));
        check("wait_pc_ack",  32'(pc_ack),        32'(e_ack && m_side == 2'b10));
        check("wait_pl_nack", 32'(pl_nack),       32'(e_nack && m_side == 2'b01));
        check("wait_pc_nack", 32'(pc_nack),       32'(e_nack && m_side == 2'b10));
        check("wait_timeout", 32'(timeout_pulse), 32'(e_to));
        check("wait_wr_en",   32'(wr_en),         32'd0);
        check("wait_clr",     32'(board_clr),     32'd0);
        if (e_ack) begin
            m_pend_pos  = pos;
            m_pend_side = m_side;
        end else if (e_to) begin
            m_side = other(m_side);
            m_wait = 0;
        end else begin
            m_wait++;
        end
        tick();
    endtask

    task automatic commit_eval(input bit do_win, input logic [1:0] who);
        idle_inputs();
        pl_req       = 1'($urandom_range(0, 1));
        pc_req       = 1'($urandom_range(0, 1));
        illegal_move = 1'($urandom_range(0, 1));
        #1;
        check("commit_wr_en",  32'(wr_en),      32'd1);
        check("commit_wr_pos", 32'(wr_pos),     32'(m_pend_pos));
        check("commit_wr_who", 32'(wr_who),     32'(m_pend_side));
        check("commit_acks",   32'({pl_ack, pc_ack, pl_nack, pc_nack}), 32'd0);
        check("commit_turn",   32'(turn),       32'd0);
        check("commit_clr",    32'(board_clr),  32'd0);
        check("commit_moves",  32'(move_count), 32'(m_moves));
        tick();
        m_board[m_pend_pos] = 1'b1;
        if (m_moves < 16) m_moves++;
        win      = do_win;
        winner   = do_win ? who : 2'($urandom_range(0, 3));
        no_space = (m_moves == 16);
        #1;
        check("eval_wr_en", 32'(wr_en),      32'd0);
        check("eval_moves", 32'(move_count), 32'(m_moves));
        check("eval_turn",  32'(turn),       32'd0);
        check("eval_acks",  32'({pl_ack, pc_ack, pl_nack, pc_nack}), 32'd0);
        tick();
        if (do_win) begin
            m_result = who;
            m_over   = 1'b1;
            if (who == 2'b01 && m_pl < SMAX) m_pl++;
            if (who == 2'b10 && m_pc < SMAX) m_pc++;
        end else if (m_moves == 16) begin
            m_result = 2'b11;
            m_over   = 1'b1;
        end else begin
            m_side = other(m_side);
            m_wait = 0;
        end
        idle_inputs();
        #1;
        check("post_over",     32'(game_over), 32'(m_over));
        check("post_result",   32'(result),    32'(m_result));
        check("post_pl_score", 32'(pl_score),  32'(m_pl));
        check("post_pc_score", 32'(pc_score),  32'(m_pc));
        check("post_turn",     32'(turn),      32'(m_over ? 2'b00 : m_side));
    endtask

    task automatic over_phase();
        int n;
        n = int'($urandom_range(2, 4));
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            pl_req       = 1'($urandom_range(0, 1));
            pc_req       = 1'($urandom_range(0, 1));
            illegal_move = 1'($urandom_range(0, 1));
            #1;
            check("over_game_over", 32'(game_over), 32'd1);
            check("over_result",    32'(result),    32'(m_result));
            check("over_moves",     32'(move_count), 32'(m_moves));
            check("over_quiet",     32'({pl_ack, pc_ack, pl_nack, pc_nack, wr_en, board_clr}), 32'd0);
            check("over_turn",      32'(turn),      32'd0);
            tick();
        end
        idle_inputs();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        #1;
        check("clear_pulse", 32'(board_clr), 32'd1);
        check("clear_over",  32'(game_over), 32'd0);
        check("clear_wr_en", 32'(wr_en),     32'd0);
        check("clear_turn",  32'(turn),      32'd0);
        model_clear();
        tick();
        check("newgame_turn",   32'(turn),       32'(m_side));
        check("newgame_moves",  32'(move_count), 32'd0);
        check("newgame_result", 32'(result),     32'd0);
        check("newgame_pl",     32'(pl_score),   32'(m_pl));
        check("newgame_clr",    32'(board_clr),  32'd0);
    endtask

    task automatic play_game(input int g);
        int         win_move;
        int         n_noise;
        bit         lazy;
        logic [1:0] who;
        if (g == 1) win_move = 0;
        else if (g == 0) win_move = 7;
        else win_move = int'($urandom_range(5, 16));
        who = (g % 4 == 3) ? 2'b10 : 2'b01;
        while (!m_over) begin
            lazy    = ($urandom_range(0, 3) == 0);
            n_noise = lazy ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, 3));
            for (int i = 0; i < n_noise; i++) wait_cycle(int'($urandom_range(0, 2)));
            wait_cycle(3);
            commit_eval((m_moves + 1) == win_move, who);
        end
        over_phase();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        m_pl         = 0;
        m_pc         = 0;
        m_first_next = 2'b01;
        reset        = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_clr",   32'(board_clr),  32'd1);
        check("rst_turn",  32'(turn),       32'd0);
        check("rst_wr_en", 32'(wr_en),      32'd0);
        check("rst_over",  32'(game_over),  32'd0);
        check("rst_moves", 32'(move_count), 32'd0);
        check("rst_result",32'(result),     32'd0);
        check("rst_scores",32'({pl_score, pc_score}), 32'd0);
        check("rst_pulses",32'({pl_ack, pc_ack, pl_nack, pc_nack, timeout_pulse}), 32'd0);
        check("rst_chk",   32'(chk_pos),    32'd0);
        reset = 1'b1;
        #1;
        check("rel_clr", 32'(board_clr), 32'd1);
        model_clear();
        tick();
        check("first_turn", 32'(turn),      32'd1);
        check("first_clr",  32'(board_clr), 32'd0);

        for (int g = 0; g < 10; g++) play_game(g);

        wait_cycle(3);
        #1;
        check("midrst_pre_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_wr_en",  32'(wr_en),      32'd0);
        check("midrst_clr",    32'(board_clr),  32'd1);
        check("midrst_turn",   32'(turn),       32'd0);
        check("midrst_scores", 32'({pl_score, pc_score}), 32'd0);
        check("midrst_moves",  32'(move_count), 32'd0);
        reset = 1'b1;
        tick();
        check("midrst_first_turn", 32'(turn), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller for the 4x4 tic-tac-toe board datapath: the position registers, the winner, illegal-move and no-space detectors.
- Arbitrates move requests from the player and the computer, and enforces strict alternation.
- Issues one write strobe per legal move, evaluates board status after each write, and declares the game over.
- Keeps the move count and per-side scores across games, and clears the board between games.

Parameters:
- SCORE_W, 4, width of the saturating win counters.
- TIMEOUT_CYC, 1000, cycles a side may wait in its turn before forfeiting it (must be ≥ 2).
- FIRST_MOVER, 2'b01, side moving first after reset: 01 = player, 10 = computer.

Ports:
- clock  in  1  game clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- pl_req  in  1  player move request, level, with pl_pos.
- pl_pos  in  4  player target cell 0..15.
- pc_req  in  1  computer move request, level, with pc_pos.
- pc_pos  in  4  computer target cell 0..15.
- new_game  in  1  pulse: start the next game from OVER.
- illegal_move  in  1  combinational board response: chk_pos is occupied.
- win  in  1  board has a winning line.
- winner  in  2  01 = player, 10 = computer; valid when win = 1.
- no_space  in  1  all 16 cells are occupied.
- chk_pos  out  4  cell under legality check; equals the current side's requested position.
- pl_ack / pc_ack  out  1  one-cycle pulse: move accepted.
- pl_nack / pc_nack  out  1  one-cycle pulse: move rejected (illegal).
- wr_en  out  1  one-cycle board write strobe.
- wr_pos  out  4  cell to write.
- wr_who  out  2  01 = player, 10 = computer.
- board_clr  out  1  one-cycle board clear pulse.
- turn  out  2  side to move (01 / 10); 00 when not in a WAIT state.
- move_count  out  5  legal moves in the current game, 0..16.
- game_over  out  1  high in OVER.
- result  out  2  00 = none, 01 = player won, 10 = computer won, 11 = draw.
- pl_score / pc_score  out  SCORE_W  games won per side.
- timeout_pulse  out  1  one-cycle pulse when a turn is forfeited.

Behaviour:
- Reset (reset = 0):
  - State is CLEAR.
  - Every output is 0, except board_clr = 1.
  - next_first = FIRST_MOVER; current side = FIRST_MOVER.
  - Timer, move_count, scores and result are cleared.
- States: CLEAR, WAIT, COMMIT, EVAL, OVER.
- CLEAR (1 cycle):
  - board_clr = 1, move_count = 0, result = 00.
  - Current side = next_first; next_first toggles.
  - Next state is WAIT. Out of reset, the first game therefore starts with FIRST_MOVER.
- WAIT:
  - turn = current side; chk_pos = that side's pos.
  - The other side's req is ignored: no ack or nack.
  - Current side req = 1 and illegal_move = 0:
    - Pulse its ack this cycle.
    - Latch the position and side.
    - Go to COMMIT.
  - Current side req = 1 and illegal_move = 1:
    - Pulse its nack.
    - Stay in WAIT; the timer keeps running.
    - A held illegal req nacks every cycle.
  - Timer: counts cycles in WAIT and resets on every WAIT entry.
  - Timer reaching TIMEOUT_CYC-1 with no acceptance:
    - Pulse timeout_pulse.
    - Toggle the side; no write; move_count unchanged.
    - Stay in WAIT; the timer restarts.
  - Acceptance takes priority over timeout in the same cycle.
- COMMIT (1 cycle):
  - wr_en = 1 with the latched wr_pos and wr_who.
  - move_count increments.
  - Next state is EVAL.
- EVAL (1 cycle): samples win, winner and no_space, which reflect the write.
  - win = 1:
    - result = winner.
    - The winner's score increments, saturating at all-ones.
    - Next state is OVER.
  - Else no_space = 1: result = 11, next state is OVER.
  - Else: toggle the side, next state is WAIT.
  - win has priority over no_space.
- OVER:
  - game_over = 1; result is held.
  - All requests are ignored; no writes occur.
  - new_game = 1 → CLEAR.
  - new_game outside OVER is ignored.
- Latency:
  - req to ack: 0 cycles (combinational in WAIT).
  - ack to wr_en: 1 cycle.
  - wr_en to next WAIT or OVER: 2 cycles.
- Exactly one of wr_en, board_clr or neither is asserted per cycle.
- move_count never exceeds 16.
- Reset asserted mid-game: immediate return to the reset state. Scores are lost; only reset clears them.

Test Plan:
- Reset release, FIRST_MOVER = 01:
  - board_clr is high 1 cycle, then turn = 01.
  - pc_req with pc_pos = 5 → no pc_ack.
  - pl_req with pl_pos = 5 → pl_ack, then wr_en with wr_pos = 5, wr_who = 01; after EVAL, turn = 10.
- Illegal move: computer requests cell 5 while illegal_move = 1 → pc_nack every cycle, no wr_en, turn stays 10. Changing to pos 6 with illegal_move = 0 → pc_ack.
- Player win:
  - Model win = 1, winner = 01 in the EVAL after the 7th move.
  - Response: game_over = 1, result = 01, pl_score 0→1, move_count = 7.
  - Later requests are ignored.
- Draw: 16 legal alternating moves with win = 0 and no_space = 1 after the 16th → result = 11, scores unchanged, move_count = 16.
- Timeout (TIMEOUT_CYC = 8): no req for 8 cycles in WAIT → timeout_pulse on the 8th cycle, turn toggles, no wr_en.
- Next game and mid-game reset:
  - new_game in OVER → board_clr, then turn = 10 (alternated first mover); pl_score is retained.
  - reset low during COMMIT → wr_en drops immediately, scores = 0, turn = 00.
